// File: rtl/hps_restart_pkg.sv
// Shared types and constants for the HPS restart sequencer.
package hps_restart_pkg;

    // Sequencer states; the numeric codes are visible to the HPS in status[2:0]
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ARMED        = 3'd1,
        ST_QUIESCE      = 3'd2,
        ST_RESET_HOLD   = 3'd3,
        ST_RELEASE_WAIT = 3'd4,
        ST_DONE         = 3'd5,
        ST_ERROR        = 3'd6
    } state_t;

    // Command codes written by the HPS into its export register
    localparam logic [7:0] CMD_ARM   = 8'hA5;
    localparam logic [7:0] CMD_FIRE  = 8'h01;
    localparam logic [7:0] CMD_ABORT = 8'h02;

    // Flag positions inside the status byte
    localparam int STATUS_FORCED_BIT      = 3;
    localparam int STATUS_ARM_EXPIRED_BIT = 4;
    localparam int STATUS_ERROR_BIT       = 5;

    // Largest of four values, used to size the shared counters
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hps_restart_sequencer_counter.sv
// Loadable down counter with a zero flag; serves as arm window counter and phase timer.
module seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; the count parks at zero instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hps_restart_sequencer.sv
// Turns HPS arm/fire/abort commands into a drain, reset pulse and ready wait of the datapath.
module hps_restart_sequencer #(
    parameter int PULSE_CYCLES    = 16,
    parameter int ARM_WINDOW      = 256,
    parameter int QUIESCE_TIMEOUT = 1024,
    parameter int READY_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] hps_cmd,
    input  logic       quiesce_ack,
    input  logic       dp_ready,
    output logic       quiesce_req,
    output logic       dp_reset_n,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] status,
    output logic [7:0] restart_count
);

    import hps_restart_pkg::*;

    localparam int MAX_PARAM = max_of4(PULSE_CYCLES, ARM_WINDOW, QUIESCE_TIMEOUT, READY_TIMEOUT);
    localparam int TW        = ($clog2(MAX_PARAM) < 1) ? 1 : $clog2(MAX_PARAM);

    localparam logic [TW-1:0] ARM_LOAD     = TW'(ARM_WINDOW - 1);
    localparam logic [TW-1:0] QUIESCE_LOAD = TW'(QUIESCE_TIMEOUT - 1);
    localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] READY_LOAD   = TW'(READY_TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [7:0]    cmd_q;
    logic          new_cmd;
    logic          arm_load;
    logic          arm_dec;
    logic          arm_zero;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_dec;
    logic          tmr_zero;
    logic          clear_flags;
    logic          set_forced;
    logic          set_expired;
    logic          set_error;
    logic          forced_flag;
    logic          expired_flag;
    logic          error_flag;

    // Previous value of the export register, so a held value is not re-executed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= 8'h00;
        end else begin
            cmd_q <= hps_cmd;
        end
    end

    assign new_cmd = (hps_cmd != cmd_q) && (hps_cmd != 8'h00);

    // Window during which a fire command is honoured after arming
    seq_down_counter #(.WIDTH(TW)) u_arm_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (arm_load),
        .load_value (ARM_LOAD),
        .dec        (arm_dec),
        .zero       (arm_zero)
    );

    // One timer reused for the quiesce, reset-pulse and ready-wait phases
    seq_down_counter #(.WIDTH(TW)) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    assign arm_dec = (state == ST_ARMED);
    assign tmr_dec = (state == ST_QUIESCE) || (state == ST_RESET_HOLD) || (state == ST_RELEASE_WAIT);

    // Transition decisions, counter loads and flag updates for the current cycle
    always_comb begin
        next_state  = state;
        arm_load    = 1'b0;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        clear_flags = 1'b0;
        set_forced  = 1'b0;
        set_expired = 1'b0;
        set_error   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_cmd && (hps_cmd == CMD_ARM)) begin
                    next_state  = ST_ARMED;
                    arm_load    = 1'b1;
                    clear_flags = 1'b1;
                end
            end
            ST_ARMED: begin
                if (new_cmd) begin
                    if (hps_cmd == CMD_ARM) begin
                        arm_load = 1'b1;
                    end else if (hps_cmd == CMD_FIRE) begin
                        next_state = ST_QUIESCE;
                        tmr_load   = 1'b1;
                        tmr_value  = QUIESCE_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else if (arm_zero) begin
                    next_state  = ST_IDLE;
                    set_expired = 1'b1;
                end
            end
            ST_QUIESCE: begin
                if (new_cmd && (hps_cmd == CMD_ABORT)) begin
                    next_state = ST_IDLE;
                end else if (quiesce_ack) begin
                    next_state = ST_RESET_HOLD;
                    tmr_load   = 1'b1;
                    tmr_value  = PULSE_LOAD;
                end else if (tmr_zero) begin
                    next_state = ST_RESET_HOLD;
                    tmr_load   = 1'b1;
                    tmr_value  = PULSE_LOAD;
                    set_forced = 1'b1;
                end
            end
            ST_RESET_HOLD: begin
                if (tmr_zero) begin
                    next_state = ST_RELEASE_WAIT;
                    tmr_load   = 1'b1;
                    tmr_value  = READY_LOAD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (dp_ready) begin
                    next_state = ST_DONE;
                end else if (tmr_zero) begin
                    next_state = ST_ERROR;
                    set_error  = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (new_cmd && (hps_cmd == CMD_ABORT)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            quiesce_req   <= 1'b0;
            dp_reset_n    <= 1'b0;
            busy          <= 1'b0;
            done_pulse    <= 1'b0;
            forced_flag   <= 1'b0;
            expired_flag  <= 1'b0;
            error_flag    <= 1'b0;
            restart_count <= 8'h00;
        end else begin
            state       <= next_state;
            quiesce_req <= (next_state == ST_QUIESCE) || (next_state == ST_RESET_HOLD) ||
                           (next_state == ST_RELEASE_WAIT);
            dp_reset_n  <= (next_state != ST_RESET_HOLD);
            busy        <= (next_state != ST_IDLE) && (next_state != ST_ERROR);
            done_pulse  <= (next_state == ST_DONE);
            if (clear_flags) begin
                forced_flag  <= 1'b0;
                expired_flag <= 1'b0;
                error_flag   <= 1'b0;
            end else begin
                if (set_forced)  forced_flag  <= 1'b1;
                if (set_expired) expired_flag <= 1'b1;
                if (set_error)   error_flag   <= 1'b1;
            end
            if ((next_state == ST_DONE) && (restart_count != 8'hFF)) begin
                restart_count <= restart_count + 8'd1;
            end
        end
    end

    assign status[2:0]                    = state;
    assign status[STATUS_FORCED_BIT]      = forced_flag;
    assign status[STATUS_ARM_EXPIRED_BIT] = expired_flag;
    assign status[STATUS_ERROR_BIT]       = error_flag;
    assign status[7:6]                    = 2'b00;

endmodule

// File: doc/hps_restart_sequencer.md
# hps_restart_sequencer

Controller that turns HPS restart commands into an ordered, guarded restart of the firewall datapath. It sits between the 8-bit HPS export register and the datapath's reset and quiesce handshake. A restart needs an arm command followed by a fire command. It then drains the datapath, holds it in reset for a fixed pulse, and waits for it to report ready. A status byte reports progress and faults back to the HPS.

## Interface
- PULSE_CYCLES, 16: cycles dp_reset_n is held low; must be ≥1
- ARM_WINDOW, 256: cycles a fire command is accepted after arm; must be ≥1
- QUIESCE_TIMEOUT, 1024: maximum cycles to wait for quiesce_ack; must be ≥1
- READY_TIMEOUT, 4096: maximum cycles to wait for dp_ready after release; must be ≥1
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- hps_cmd  in  8  HPS export register; same clock domain as clk
- quiesce_ack  in  1  datapath has drained and is idle
- dp_ready  in  1  datapath is initialised after reset
- quiesce_req  out  1  request to the datapath to stop accepting traffic and drain
- dp_reset_n  out  1  datapath reset, active-low
- busy  out  1  high in any state other than IDLE or ERROR
- done_pulse  out  1  one-cycle pulse on successful completion
- status  out  8  [2:0] state code; [3] forced; [4] arm_expired; [5] error; [7:6] reserved, read as 0
- restart_count  out  8  successful restarts; saturates at 255

## Operation
- Command decode:
  - cmd_q holds hps_cmd registered every cycle.
  - A new command is a cycle where hps_cmd ≠ cmd_q and hps_cmd ≠ 0x00.
  - Re-writing the same value is not a new command. The HPS writes 0x00 between identical commands.
- Command codes: ARM = 0xA5, FIRE = 0x01, ABORT = 0x02. Any other nonzero value is INVALID.
- States and codes: IDLE = 0, ARMED = 1, QUIESCE = 2, RESET_HOLD = 3, RELEASE_WAIT = 4, DONE = 5, ERROR = 6.
- IDLE:
  - Outputs: quiesce_req = 0, dp_reset_n = 1.
  - New ARM → ARMED. Load arm counter = ARM_WINDOW−1. Clear status[5:3].
  - Every other command is ignored.
- ARMED:
  - New FIRE → QUIESCE. Load timer = QUIESCE_TIMEOUT−1.
  - New ABORT or INVALID → IDLE.
  - New ARM reloads the arm counter.
  - Arm counter at 0 with no command → IDLE and set arm_expired.
- QUIESCE:
  - quiesce_req = 1.
  - quiesce_ack → RESET_HOLD.
  - Timer at 0 without ack → RESET_HOLD and set forced.
  - New ABORT → IDLE and drop quiesce_req.
  - Either RESET_HOLD entry loads timer = PULSE_CYCLES−1.
- RESET_HOLD:
  - dp_reset_n = 0, quiesce_req = 1. All commands are ignored.
  - Timer at 0 → RELEASE_WAIT. Load timer = READY_TIMEOUT−1.
- RELEASE_WAIT:
  - dp_reset_n = 1, quiesce_req = 1.
  - dp_ready → DONE.
  - Timer at 0 → ERROR and set error.
- DONE:
  - Lasts one cycle. done_pulse = 1, quiesce_req = 0.
  - Increment restart_count, saturating at 255.
  - → IDLE.
- ERROR:
  - quiesce_req = 0, dp_reset_n = 1.
  - Only a new ABORT → IDLE. The error flag stays set until the next ARM.
- Simultaneous events:
  - QUIESCE: ABORT beats ack, ack beats timeout. When ack and timeout coincide, forced stays 0.
  - RELEASE_WAIT: dp_ready beats timeout.
  - ARMED: a new command beats arm expiry.
- Reset behaviour:
  - All state, timers, flags and counters clear; state = IDLE.
  - Reset mid-operation abandons the sequence; no done_pulse is produced.

## Timing
- Reset values: quiesce_req = 0, dp_reset_n = 0, busy = 0, done_pulse = 0, status = 0x00, restart_count = 0, cmd_q = 0x00.
- dp_reset_n rises at the first clk edge after reset_n deasserts, because IDLE drives 1.
- All outputs are registered. An hps_cmd change before edge k is reflected on outputs after edge k (latency 1).
- FIRE at edge k:
  - quiesce_req = 1 after edge k.
  - An ack sampled at edge m gives dp_reset_n = 0 after edge m.
  - dp_reset_n stays low for exactly PULSE_CYCLES cycles.
- dp_ready sampled at edge r gives done_pulse high during the cycle after r, then IDLE.
- Timeouts: exactly N cycles spent in the state before the timeout transition fires (timer loaded with N−1, compared to 0).
- Timer widths are $clog2 of the largest parameter.

## Structure
- hps_restart_pkg holds:
  - state enum with the codes above
  - command constants CMD_ARM, CMD_FIRE, CMD_ABORT
  - status bit index localparams
- One shared sub-module, seq_down_counter (load value, load strobe, decrement, zero flag, parameterised width). It serves the arm counter and the phase timer.
- One instance each: the phase timer is reused across QUIESCE, RESET_HOLD and RELEASE_WAIT.

## Test plan
- Normal restart:
  - Stimulus: ARM 0xA5, FIRE 0x01 five cycles later, ack after 10 cycles, dp_ready 20 cycles after release.
  - Response: dp_reset_n low for 16 cycles, one done_pulse, restart_count = 1, status = 0x00 with state IDLE.
- FIRE without ARM, from IDLE → no state change; quiesce_req stays 0.
- Arm expiry: ARM, then idle for 256 cycles → IDLE and status = 0x10.
- Quiesce timeout: ack never asserted → RESET_HOLD entered exactly 1024 cycles after QUIESCE entry, status[3] = 1, sequence completes.
- Ready timeout: dp_ready never asserted → ERROR, status = 0x26. ABORT → IDLE. ARM clears status[5].
- Boundaries:
  - ABORT and ack in the same QUIESCE cycle → IDLE, and dp_reset_n never drops.
  - reset_n asserted mid-RESET_HOLD → all outputs take their reset values immediately.
  - 256 restarts → restart_count = 255.
